// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset control FSM.
// Holds the state encoding, ALU operation codes, opcodes and trap causes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_WB_ALU,
        ST_ADDR,
        ST_MEM_RD,
        ST_WB_MEM,
        ST_MEM_WR,
        ST_BRANCH,
        ST_TRAP
    } state_e;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILL_OP  = 2'd1;
    localparam logic [1:0] CAUSE_ILL_BR  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    // States that hold an outstanding request on the memory port.
    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_mem_wait_timer.sv
// Counts stalled cycles of an outstanding memory request and flags expiry
// when the request is still unanswered in its MEM_TIMEOUT-th cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(MEM_TIMEOUT);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for an RV32I-subset datapath: sequences fetch,
// decode, execute, memory and writeback, retires instructions and traps.
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             srcb_hold_q, srcb_hold_d;
    logic             retire;
    logic             in_mem;
    logic             tmo_clr;
    logic             tmo_en;
    logic             tmo_expired;
    logic             br_legal;
    logic             br_taken;

    // Timer runs only while a request is stalled; any completion or leaving
    // the memory states rearms it, so every new request starts from zero.
    assign in_mem  = is_mem_state(state_q);
    assign tmo_clr = !in_mem || mem_ready;
    assign tmo_en  = in_mem && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    assign br_legal = (func3 == F3_BEQ) || (func3 == F3_BNE);
    assign br_taken = (func3 == F3_BEQ) ? alu_zero : !alu_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cause_q     <= CAUSE_NONE;
            retired_q   <= '0;
            srcb_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            retired_q   <= retired_d;
            srcb_hold_q <= srcb_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        srcb_hold_d = srcb_hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R:              state_d = ST_EXEC_R;
                    OP_I:              state_d = ST_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = ST_ADDR;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILL_OP;
                    end
                endcase
            end
            ST_EXEC_R: begin
                state_d     = ST_WB_ALU;
                srcb_hold_d = 1'b0;
            end
            ST_EXEC_I: begin
                state_d     = ST_WB_ALU;
                srcb_hold_d = 1'b1;
            end
            ST_WB_ALU: retire = 1'b1;
            ST_ADDR: begin
                state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_WB_MEM;
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WB_MEM: retire = 1'b1;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    retire = 1'b1;
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_BRANCH: begin
                if (br_legal) begin
                    retire = 1'b1;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILL_BR;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
        retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            ST_EXEC_R: alu_op = ALU_FUNC;
            ST_EXEC_I: begin
                alu_src_b = 1'b1;
                alu_op    = ALU_FUNC;
            end
            ST_WB_ALU: begin
                alu_src_b = srcb_hold_q;
                alu_op    = ALU_FUNC;
                reg_we    = 1'b1;
            end
            ST_ADDR: alu_src_b = 1'b1;
            ST_MEM_RD: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                alu_src_b = 1'b1;
            end
            ST_WB_MEM: begin
                reg_we = 1'b1;
                wb_sel = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                addr_sel  = 1'b1;
                alu_src_b = 1'b1;
            end
            ST_BRANCH: begin
                alu_op = ALU_SUB;
                pc_we  = br_legal && br_taken;
                pc_src = br_legal && br_taken;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class, branch
// outcomes, illegal encodings, memory timeout and reset behaviour.
module tb_mc_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic             alu_zero;
    logic             mem_ready;
    logic             mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
    logic             alu_src_b, reg_we, wb_sel, busy, trap;
    logic [1:0]       alu_op, trap_cause;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ret  = 0;

    mc_ctrl_fsm #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .func3      (func3),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .busy       (busy),
        .trap       (trap),
        .trap_cause (trap_cause),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_trap", trap, 0);
        check("rst_cause", trap_cause, 0);
        check("rst_retired", retired, 0);
        check("rst_busy", busy, 0);
        run = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic branch_case(input logic [2:0] f3, input logic z, input logic exp_we);
        opcode = OP_BRANCH; func3 = f3; alu_zero = z; mem_ready = 1'b1; run = 1'b1;
        cyc();
        run = 1'b0;
        cyc();
        cyc();
        check("br_pc_we", pc_we, exp_we);
        check("br_pc_src", pc_src, exp_we);
        check("br_alu_op", alu_op, ALU_SUB);
        check("br_srcb", alu_src_b, 0);
        cyc();
        exp_ret++;
        check("br_retired", retired, exp_ret);
        check("br_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = OP_R; func3 = 3'b000; alu_zero = 1'b0;
        cyc();
        cyc();
        check("reset_mem_req", mem_req, 0);
        check("reset_busy", busy, 0);
        check("reset_retired", retired, 0);
        check("reset_trap", trap, 0);
        check("reset_strobes", {ir_we, pc_we, reg_we, mem_we}, 0);
        rst_n = 1'b1;

        // R-type, then I-type back to back
        cyc();
        check("r_fetch_req", mem_req, 1);
        check("r_fetch_irwe", {ir_we, pc_we, pc_src, addr_sel}, 4'b1100);
        check("r_fetch_busy", busy, 1);
        cyc();
        check("r_dec_strobes", {mem_req, ir_we, pc_we, reg_we}, 0);
        cyc();
        check("r_exec_op", alu_op, ALU_FUNC);
        check("r_exec_srcb", alu_src_b, 0);
        check("r_exec_regwe", reg_we, 0);
        cyc();
        check("r_wb_regwe", reg_we, 1);
        check("r_wb_sel", wb_sel, 0);
        check("r_wb_op", alu_op, ALU_FUNC);
        check("r_wb_retired", retired, 0);
        opcode = OP_I;
        cyc();
        check("r_retired", retired, 1);
        check("i_fetch_req", mem_req, 1);
        cyc();
        cyc();
        check("i_exec_srcb", alu_src_b, 1);
        cyc();
        check("i_wb_srcb", alu_src_b, 1);
        check("i_wb_regwe", reg_we, 1);
        opcode = OP_LOAD;

        // Load with three stall cycles in MEM_RD
        cyc();
        check("i_retired", retired, 2);
        cyc();
        cyc();
        check("ld_addr_srcb", alu_src_b, 1);
        check("ld_addr_op", alu_op, ALU_ADD);
        check("ld_addr_req", mem_req, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("ld_rd_req", {mem_req, addr_sel, mem_we}, 3'b110);
            check("ld_rd_trap", trap, 0);
        end
        cyc();
        check("ld_wb", {reg_we, wb_sel, mem_req}, 3'b110);
        run = 1'b0;
        cyc();
        check("ld_retired", retired, 3);
        check("ld_idle", busy, 0);
        exp_ret = 3;

        // Branches: taken / not taken for BEQ and BNE, then illegal func3
        branch_case(F3_BEQ, 1'b1, 1'b1);
        branch_case(F3_BEQ, 1'b0, 1'b0);
        branch_case(F3_BNE, 1'b0, 1'b1);
        branch_case(F3_BNE, 1'b1, 1'b0);
        opcode = OP_BRANCH; func3 = 3'b100; alu_zero = 1'b1; run = 1'b1;
        cyc();
        run = 1'b0;
        cyc();
        cyc();
        check("bill_pc_we", pc_we, 0);
        cyc();
        check("bill_trap", trap, 1);
        check("bill_cause", trap_cause, CAUSE_ILL_BR);
        check("bill_busy", busy, 0);
        check("bill_retired", retired, 7);
        rst_pulse();

        // Illegal opcode: trap is sticky regardless of inputs
        opcode = 7'b1111111; func3 = 3'b000; run = 1'b1; mem_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        check("iop_trap", trap, 1);
        check("iop_cause", trap_cause, CAUSE_ILL_OP);
        check("iop_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            alu_zero  = 1'b1;
            cyc();
            check("iop_hold_trap", trap, 1);
            check("iop_strobes", {mem_req, ir_we, pc_we, reg_we, mem_we, pc_src}, 0);
        end
        rst_pulse();
        cyc();
        check("iop_after_idle", busy, 0);

        // Fetch timeout with MEM_TIMEOUT = 4
        mem_ready = 1'b0; opcode = OP_STORE; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("to_req", mem_req, 1);
            check("to_no_trap", trap, 0);
        end
        cyc();
        check("to_trap", trap, 1);
        check("to_cause", trap_cause, CAUSE_TIMEOUT);
        check("to_req_drop", mem_req, 0);
        rst_pulse();

        // mem_ready on the limit cycle wins; then a store with run dropped
        run = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("lim_req", mem_req, 1);
            if (i == 3) check("lim_irwe", ir_we, 1);
        end
        run = 1'b0;
        cyc();
        check("lim_decode", {trap, busy, mem_req}, 3'b010);
        cyc();
        mem_ready = 1'b0;
        cyc();
        check("st_req", {mem_req, mem_we, addr_sel}, 3'b111);
        cyc();
        mem_ready = 1'b1;
        #1;
        check("st_req_held", {mem_req, mem_we}, 2'b11);
        check("st_retired_pre", retired, 0);
        cyc();
        check("st_retired", retired, 1);
        check("st_idle", {busy, mem_req}, 0);

        // Reset asserted mid-fetch drops mem_req without a clock edge
        mem_ready = 1'b0; run = 1'b1;
        cyc();
        check("mf_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("mf_req_drop", mem_req, 0);
        check("mf_busy", busy, 0);
        check("mf_retired", retired, 0);
        run = 1'b0;
        rst_n = 1'b1;
        cyc();
        check("mf_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
